// File: rtl/intr_ctrl.sv
// intr_ctrl -- prioritised interrupt controller in front of a CP0 external
// interrupt input.
//
// Sources are qualified per bit as edge- or level-triggered, gated by a mask
// and arbitrated lowest-index-first. A three-state handshake (IDLE -> REQ ->
// SERVICE) raises ir_out, waits for the core to take the interrupt (ir_ack)
// and then holds off further requests until end of interrupt (eoi).
//
// Ports
//   clk        main clock, all state on the rising edge
//   rst        synchronous active-high reset
//   src_in     raw interrupt lines (N_SRC wide, synchronous to clk)
//   reg_we     register write strobe
//   reg_addr   0 MASK, 1 PENDING (W1C), 2 EDGE_SEL, 3 STATUS (RO)
//   reg_wdata  register write data
//   reg_rdata  registered read data, one cycle after reg_addr is sampled
//   ir_out     interrupt request to CP0
//   ir_ack     CP0 has taken the interrupt
//   eoi        end of interrupt (ERET)
//   ir_id      index of the source being requested or serviced
//   busy       high while the handler is running (SERVICE)
module intr_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             ir_out,
  input  logic             ir_ack,
  input  logic             eoi,
  output logic [4:0]       ir_id,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_REQ     = 2'b01;
  localparam logic [1:0] ST_SERVICE = 2'b10;

  logic [N_SRC-1:0] mask_reg, edge_sel_reg, pending_reg, src_q_reg;
  logic [N_SRC-1:0] pending_next;
  logic [1:0]       state_reg, state_next;
  logic [4:0]       ir_id_reg, ir_id_next;
  logic [31:0]      rdata_reg, rdata_next;

  logic [N_SRC-1:0] rise, w1c, eligible, id_sel, ack_clr;
  logic [4:0]       winner;
  logic             any_eligible, id_eligible, ack_taken;

  assign rise      = src_in & ~src_q_reg;
  assign w1c       = (reg_we && reg_addr == 2'd1) ? reg_wdata[N_SRC-1:0] : '0;
  assign eligible  = pending_reg & mask_reg;
  assign ack_taken = (state_reg == ST_REQ) && ir_ack;

  // Per-source pending logic. A new rising edge beats any clear arriving in
  // the same cycle; level sources simply track the sampled line.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign id_sel[gi]  = (ir_id_reg == 5'(gi));
      assign ack_clr[gi] = ack_taken && id_sel[gi];
      assign pending_next[gi] = edge_sel_reg[gi]
          ? (rise[gi] | (pending_reg[gi] & ~w1c[gi] & ~ack_clr[gi]))
          : src_in[gi];
    end
  endgenerate

  assign any_eligible = |eligible;
  // ir_id is only ever loaded from the arbiter, so it always names a real source.
  assign id_eligible  = |(eligible & id_sel);

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 5'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_id_next = ir_id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_eligible) begin
          state_next = ST_REQ;
          ir_id_next = winner;
        end
      end
      ST_REQ: begin
        // Acknowledge takes precedence over a simultaneous withdrawal.
        if (ir_ack)            state_next = ST_SERVICE;
        else if (!id_eligible) state_next = ST_IDLE;
      end
      ST_SERVICE: begin
        if (eoi) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_next = '0;
    case (reg_addr)
      2'd0: rdata_next = 32'(mask_reg);
      2'd1: rdata_next = 32'(pending_reg);
      2'd2: rdata_next = 32'(edge_sel_reg);
      2'd3: rdata_next = {23'd0, (state_reg == ST_SERVICE), state_reg, 1'b0, ir_id_reg};
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg     <= '0;
      edge_sel_reg <= '0;
      pending_reg  <= '0;
      src_q_reg    <= '0;
      state_reg    <= ST_IDLE;
      ir_id_reg    <= '0;
      rdata_reg    <= '0;
    end else begin
      if (reg_we && reg_addr == 2'd0) mask_reg     <= reg_wdata[N_SRC-1:0];
      if (reg_we && reg_addr == 2'd2) edge_sel_reg <= reg_wdata[N_SRC-1:0];
      pending_reg <= pending_next;
      src_q_reg   <= src_in;
      state_reg   <= state_next;
      ir_id_reg   <= ir_id_next;
      rdata_reg   <= rdata_next;
    end
  end

  // Both flags decode straight from the state register, so they change
  // exactly at the state transition edge.
  assign ir_out    = (state_reg == ST_REQ);
  assign busy      = (state_reg == ST_SERVICE);
  assign ir_id     = ir_id_reg;
  assign reg_rdata = rdata_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl -- directed scenarios followed by random traffic, every cycle
// checked against a behavioural model of the interrupt controller.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src_in;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        ir_out;
  logic        ir_ack;
  logic        eoi;
  logic [4:0]  ir_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model state: plain bit arrays and a numeric phase (0 idle, 1 req, 2 service).
  bit [7:0]  m_mask, m_edge, m_pend, m_srcq;
  int        m_phase;
  int        m_id;
  bit [31:0] m_rdata;

  intr_ctrl #(.N_SRC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_in    (src_in),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .ir_out    (ir_out),
    .ir_ack    (ir_ack),
    .eoi       (eoi),
    .ir_id     (ir_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", name, obs, exp);
      end
  endtask

  // Apply one clock edge of the controller's rules to the model.
  task automatic model_edge();
    int  win;
    bit  acked;
    int  old_id;
    bit [7:0] new_pend;
    if (rst) begin
      m_mask = 0; m_edge = 0; m_pend = 0; m_srcq = 0;
      m_phase = 0; m_id = 0; m_rdata = 0;
      return;
    end
    case (reg_addr)
      2'd0: m_rdata = {24'd0, m_mask};
      2'd1: m_rdata = {24'd0, m_pend};
      2'd2: m_rdata = {24'd0, m_edge};
      default: m_rdata = (((m_phase == 2) ? 32'd1 : 32'd0) << 8)
                         | (32'(m_phase) << 6) | 32'(m_id);
    endcase
    win = -1;
    for (int i = 7; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
    acked  = 0;
    old_id = m_id;
    if (m_phase == 0) begin
      if (win >= 0) begin m_phase = 1; m_id = win; end
    end else if (m_phase == 1) begin
      if (ir_ack) begin m_phase = 2; acked = 1; end
      else if (!(m_pend[old_id] && m_mask[old_id])) m_phase = 0;
    end else begin
      if (eoi) m_phase = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_edge[i]) begin
        bit cleared;
        cleared = (reg_we && reg_addr == 2'd1 && reg_wdata[i]) || (acked && i == old_id);
        new_pend[i] = (src_in[i] && !m_srcq[i]) || (m_pend[i] && !cleared);
      end else begin
        new_pend[i] = src_in[i];
      end
    end
    m_pend = new_pend;
    if (reg_we && reg_addr == 2'd0) m_mask = reg_wdata[7:0];
    if (reg_we && reg_addr == 2'd2) m_edge = reg_wdata[7:0];
    m_srcq = src_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("ir_out", 32'(ir_out), 32'(m_phase == 1));
    check("busy",   32'(busy),   32'(m_phase == 2));
    check("ir_id",  32'(ir_id),  32'(m_id));
    check("rdata",  reg_rdata,   m_rdata);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  initial begin
    rst = 1'b1; src_in = '0; reg_we = 1'b0; reg_addr = 2'd0;
    reg_wdata = '0; ir_ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_rdata", reg_rdata, 32'd0);

    // Edge source 2: pending, request, acknowledge clears pending.
    wr(2'd0, 32'h05);
    wr(2'd2, 32'h05);
    reg_addr = 2'd1;
    src_in = 8'h04; tick();
    src_in = 8'h00; tick();
    check("v030_irout", 32'(ir_out), 32'd1);
    check("v030_id",    32'(ir_id),  32'd2);
    check("v030_pend",  reg_rdata,   32'h04);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    check("v030_busy",  32'(busy),   32'd1);
    tick();
    check("v030_clr",   reg_rdata,   32'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Sources 0 and 2 together: 0 first, 2 after eoi.
    src_in = 8'h05; tick();
    src_in = 8'h00; tick();
    check("v031_first", 32'(ir_id), 32'd0);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    check("v031_second", 32'(ir_id), 32'd2);
    check("v031_irout",  32'(ir_out), 32'd1);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Masking withdraws a request; unmasking reissues it.
    wr(2'd0, 32'h0D);
    wr(2'd2, 32'h0D);
    reg_addr = 2'd1;
    src_in = 8'h08; tick();
    src_in = 8'h00; tick();
    check("v032_id", 32'(ir_id), 32'd3);
    wr(2'd0, 32'h05);
    reg_addr = 2'd1;
    tick();
    check("v032_withdraw", 32'(ir_out), 32'd0);
    check("v032_pend",     reg_rdata & 32'h08, 32'h08);
    wr(2'd0, 32'h0D);
    tick();
    check("v032_reissue", 32'(ir_out), 32'd1);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Reset during SERVICE, then a stray eoi.
    src_in = 8'h01; tick();
    src_in = 8'h00; tick();
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    check("v034_busy_before", 32'(busy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("v034_busy", 32'(busy), 32'd0);
    check("v034_rd",   reg_rdata, 32'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("v034_eoi", 32'(ir_out), 32'd0);

    // W1C colliding with a fresh edge keeps the bit set.
    wr(2'd2, 32'h05);
    src_in = 8'h01; tick();
    src_in = 8'h00; tick();
    src_in = 8'h01;
    wr(2'd1, 32'h01);
    src_in = 8'h00;
    reg_addr = 2'd1;
    tick(); tick();
    check("v035_pend", reg_rdata & 32'h01, 32'h01);

    // Level source 1: re-asserts after eoi, withdraws when dropped.
    wr(2'd1, 32'h01);
    wr(2'd0, 32'h02);
    src_in = 8'h02; tick(); tick();
    check("v033_req", 32'(ir_id), 32'd1);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    check("v033_again", 32'(ir_out), 32'd1);
    src_in = 8'h00; tick(); tick();
    check("v033_drop", 32'(ir_out), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) src_in = src_in ^ 8'($urandom_range(0, 255));
      reg_we    = ($urandom_range(0, 5) == 0);
      reg_addr  = 2'($urandom_range(0, 3));
      reg_wdata = $urandom;
      ir_ack    = ($urandom_range(0, 3) == 0);
      eoi       = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have parameter N_SRC, default 8, meaning number of external interrupt sources, legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1, the single main clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port src_in, input, N_SRC, raw interrupt request lines, synchronous to clk.
REQ-005 The block SHALL have port reg_we, input, 1, register write strobe.
REQ-006 The block SHALL have port reg_addr, input, 2, register select: 0 MASK, 1 PENDING, 2 EDGE_SEL, 3 STATUS.
REQ-007 The block SHALL have port reg_wdata, input, 32, register write data.
REQ-008 The block SHALL have port reg_rdata, output, 32, registered read data.
REQ-009 The block SHALL have port ir_out, output, 1, interrupt request to the CP0 external interrupt input.
REQ-010 The block SHALL have port ir_ack, input, 1, CP0 has taken the interrupt (force-jump to handler).
REQ-011 The block SHALL have port eoi, input, 1, end of interrupt (ERET executed).
REQ-012 The block SHALL have port ir_id, output, 5, index of the source being requested or serviced.
REQ-013 The block SHALL have port busy, output, 1, high while in state SERVICE.

Function
REQ-014 Registers: MASK (RW, 1 = enabled); EDGE_SEL (RW, 1 = edge, 0 = level); PENDING (read; write-1-to-clear, edge sources only); STATUS (RO) = {busy at bit 8, state at bits 7:6, ir_id at bits 4:0}. Bits at and above N_SRC SHALL read 0 and ignore writes.
REQ-015 Read latency SHALL be one cycle: reg_rdata after edge n reflects reg_addr sampled at edge n, regardless of reg_we.
REQ-016 src_q SHALL register src_in every cycle; edge detect = src_in & ~src_q.
REQ-017 Edge source pending bit SHALL set at the edge where the rising edge is detected, and hold until cleared by ir_ack for that id or by a W1C write.
REQ-018 Level source pending bit SHALL equal src_in registered each cycle; W1C and ir_ack SHALL have no effect on it.
REQ-019 A set and a clear of the same pending bit in the same cycle SHALL leave it set.
REQ-020 Eligible = PENDING & MASK; winner = lowest eligible index (index 0 highest priority).
REQ-021 FSM states SHALL be IDLE (00), REQ (01), SERVICE (10).
REQ-022 IDLE: if any eligible bit, latch winner into ir_id, go to REQ, and set ir_out = 1 at the same edge; else remain in IDLE.
REQ-023 REQ: ir_out SHALL hold 1 and ir_id SHALL be stable until ir_ack. On ir_ack, go to SERVICE, set ir_out = 0, and clear the pending bit of ir_id if it is an edge source.
REQ-024 REQ withdrawal: if the bit for ir_id leaves the eligible set without ir_ack (masked, W1C, or level dropped), go to IDLE with ir_out = 0. If ir_ack arrives in the same cycle, ir_ack wins.
REQ-025 SERVICE: busy = 1 and ir_out = 0. No nesting: further eligible sources stay pending. On eoi, go to IDLE.
REQ-026 ir_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-027 Latency: an edge source first sampled high at edge n with the block in IDLE and the source unmasked SHALL give ir_out = 1 after edge n+1. After eoi at edge m, a still-eligible source SHALL give ir_out = 1 after edge m+1.

Reset
REQ-028 On rst at any edge, including mid-REQ or mid-SERVICE, the block SHALL set MASK = 0, EDGE_SEL = 0, PENDING = 0, src_q = 0, state = IDLE, ir_out = 0, ir_id = 0, busy = 0, and reg_rdata = 0.
REQ-029 While rst is high, writes and src_in SHALL be ignored.

Verification
REQ-030 Write MASK = 0x05 and EDGE_SEL = 0x05, pulse src_in[2] at edge 10 -> PENDING[2] = 1 after edge 10, ir_out = 1 and ir_id = 2 after edge 11; ir_ack -> busy = 1, ir_out = 0, PENDING[2] = 0.
REQ-031 Edge sources 0 and 2 rising in the same cycle -> ir_id = 0 first; after ir_ack and eoi -> ir_out re-rises one cycle later with ir_id = 2.
REQ-032 In REQ for id 3, write MASK bit 3 = 0 -> ir_out = 0 and state IDLE next cycle; PENDING[3] remains 1; re-enable the mask -> request reissued.
REQ-033 Level source 1 held high through ir_ack and eoi -> ir_out re-asserts after eoi; src_in[1] dropped during REQ -> withdrawal.
REQ-034 Assert rst during SERVICE -> all outputs 0 next cycle; a subsequent eoi is ignored.
REQ-035 W1C PENDING coinciding with a new edge on the same bit -> bit remains 1; read PENDING -> value on reg_rdata one cycle later.
